// File: rtl/line_buffer_stream_reader_if.sv
// AXI4-Stream video link from the line-buffer reader to the downstream sink.
// A beat transfers on a rising clock edge where TVALID and TREADY are both 1; once TVALID rises, TDATA/TUSER/TLAST stay fixed until that beat transfers.
interface line_buffer_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;
    logic                  M_AXIS_TUSER;
    logic                  M_AXIS_TLAST;

    modport master (
        output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/line_buffer_stream_reader.sv
// Sweeps the ping-pong line cache once per completed camera line and streams
// the returned YUV words as AXI4-Stream video, credit-limited so backpressure never drops data.
module line_buffer_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 640,
    parameter int RD_LATENCY = 1
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          VSYNC,
    input  logic                          LINE_SEL,
    input  logic                          RD_EN,
    output logic [ADDR_WIDTH-1:0]         ADDRB,
    input  logic [DATA_WIDTH-1:0]         DATA_IN,
    line_buffer_stream_reader_if.master   m_axis,
    output logic                          OVERRUN,
    output logic [15:0]                   LINE_CNT,
    output logic [1:0]                    state_dbg
);
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_WORDS - 1);

    // Encoding is visible on state_dbg: 0 idle, 1 reading, 2 draining.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
    state_t state;

    logic [1:0] vsync_s, line_sel_s, rd_en_s;
    logic       vsync_d, line_sel_d;
    logic [2:0] arm;
    logic       line_evt, vsync_rise;
    logic       pending, sof_pending;

    logic [RD_LATENCY-1:0] fl_v, fl_last, fl_sof;
    logic [DATA_WIDTH+1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt, inflight;
    logic [DATA_WIDTH+1:0] head;
    logic                  issue, push, pop, line_done;

    // Edge detectors ignore the first cycles after reset, until the delayed copies hold real input values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_s    <= '0;
            line_sel_s <= '0;
            rd_en_s    <= '0;
            vsync_d    <= 1'b0;
            line_sel_d <= 1'b0;
            arm        <= '0;
        end else begin
            vsync_s    <= {vsync_s[0], VSYNC};
            line_sel_s <= {line_sel_s[0], LINE_SEL};
            rd_en_s    <= {rd_en_s[0], RD_EN};
            vsync_d    <= vsync_s[1];
            line_sel_d <= line_sel_s[1];
            arm        <= {arm[1:0], 1'b1};
        end
    end

    assign line_evt   = arm[2] && rd_en_s[1] && (line_sel_s[1] ^ line_sel_d);
    assign vsync_rise = arm[2] && vsync_s[1] && !vsync_d;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(fl_v[i]);
    end

    assign head      = fifo_mem[rd_ptr];
    assign issue     = (state == READ) && ((int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH);
    assign push      = fl_v[RD_LATENCY-1];
    assign pop       = m_axis.M_AXIS_TVALID && m_axis.M_AXIS_TREADY;
    assign line_done = (state == DRAIN) && pop && head[DATA_WIDTH];

    assign m_axis.M_AXIS_TVALID = (fifo_cnt != '0);
    assign m_axis.M_AXIS_TDATA  = head[DATA_WIDTH-1:0];
    assign m_axis.M_AXIS_TLAST  = m_axis.M_AXIS_TVALID && head[DATA_WIDTH];
    assign m_axis.M_AXIS_TUSER  = m_axis.M_AXIS_TVALID && head[DATA_WIDTH+1];
    assign state_dbg            = state;

    // Each issued read carries its last/sof tags until DATA_IN lands.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fl_v    <= '0;
            fl_last <= '0;
            fl_sof  <= '0;
        end else begin
            fl_v[0]    <= issue;
            fl_last[0] <= (ADDRB == LAST_ADDR);
            fl_sof[0]  <= (ADDRB == '0) && sof_pending;
            for (int i = 1; i < RD_LATENCY; i++) begin
                fl_v[i]    <= fl_v[i-1];
                fl_last[i] <= fl_last[i-1];
                fl_sof[i]  <= fl_sof[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {fl_sof[RD_LATENCY-1], fl_last[RD_LATENCY-1], DATA_IN};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            ADDRB       <= '0;
            pending     <= 1'b0;
            sof_pending <= 1'b0;
            OVERRUN     <= 1'b0;
            LINE_CNT    <= '0;
        end else begin
            case (state)
                IDLE:  if (pending) state <= READ;
                READ: begin
                    if (issue) begin
                        if (ADDRB == LAST_ADDR) begin
                            ADDRB <= '0;
                            state <= DRAIN;
                        end else begin
                            ADDRB <= ADDRB + 1'b1;
                        end
                    end
                end
                DRAIN: if (line_done) state <= IDLE;
                default: state <= IDLE;
            endcase

            // An event landing on the same cycle the idle FSM consumes the flag is a fresh line, not an overrun.
            if (line_evt) begin
                pending <= 1'b1;
                if (pending && state != IDLE) OVERRUN <= 1'b1;
            end else if (state == IDLE) begin
                pending <= 1'b0;
            end

            if (vsync_rise)                        sof_pending <= 1'b1;
            else if (issue && ADDRB == '0)         sof_pending <= 1'b0;

            if (vsync_rise)     LINE_CNT <= '0;
            else if (line_done) LINE_CNT <= LINE_CNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_line_buffer_stream_reader.sv
// Bench for line_buffer_stream_reader: two instances (read latency 1 and 2) share
// stimulus; expected beats come from a line-level model pushed into per-instance queues.
`timescale 1ns/1ps
module tb_line_buffer_stream_reader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int EW = DW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic line_sel = 1'b0;
    logic rd_en = 1'b0;
    logic tready;
    int   rdy_mode = 0;

    logic [AW-1:0] addrb0, addrb1;
    logic [DW-1:0] din0, din1;
    logic          ovr0, ovr1;
    logic [15:0]   lc0, lc1;
    logic [1:0]    st0, st1;

    line_buffer_stream_reader_if #(.DATA_WIDTH(DW)) s0 ();
    line_buffer_stream_reader_if #(.DATA_WIDTH(DW)) s1 ();
    assign s0.M_AXIS_TREADY = tready;
    assign s1.M_AXIS_TREADY = tready;

    line_buffer_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .RD_LATENCY(1)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .LINE_SEL(line_sel), .RD_EN(rd_en),
        .ADDRB(addrb0), .DATA_IN(din0), .m_axis(s0), .OVERRUN(ovr0), .LINE_CNT(lc0), .state_dbg(st0));

    line_buffer_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .RD_LATENCY(2)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .LINE_SEL(line_sel), .RD_EN(rd_en),
        .ADDRB(addrb1), .DATA_IN(din1), .m_axis(s1), .OVERRUN(ovr1), .LINE_CNT(lc1), .state_dbg(st1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- line cache + converter model ----------------
    logic [DW-1:0] mem [LW];
    logic [AW-1:0] a0_q, a1_q, a1_qq;
    always @(posedge clk) begin
        a0_q  <= addrb0;
        a1_q  <= addrb1;
        a1_qq <= a1_q;
    end
    assign din0 = mem[int'(a0_q) % LW];
    assign din1 = mem[int'(a1_qq) % LW];

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int   compared = 0;
    int   mismatched = 0;
    logic exp_sof = 1'b0;
    int   exp_line_cnt = 0;
    logic exp_ovr = 1'b0;
    logic gapless = 1'b0;
    logic          stall_prev [2];
    logic [EW-1:0] stall_word [2];
    logic          run_prev [2];
    int            beats_seen [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            stall_prev[k] = 1'b0;
            stall_word[k] = '0;
            run_prev[k]   = 1'b0;
            beats_seen[k] = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                2:       tready = ($urandom_range(0, 3) != 0);
                default: tready = 1'b0;
            endcase
        end
    end

    // Reference model: an accepted line is LW beats of mem[], TUSER on word 0 of the first line after VSYNC, TLAST on the final word.
    task automatic push_line();
        logic [EW-1:0] e;
        for (int i = 0; i < LW; i++) begin
            e = {exp_sof && (i == 0), (i == LW - 1), mem[i]};
            exp_q0.push_back(e);
            exp_q1.push_back(e);
        end
        exp_sof = 1'b0;
        exp_line_cnt++;
    endtask

    task automatic vsync_rise();
        vsync = 1'b1;
        exp_sof = 1'b1;
        exp_line_cnt = 0;
    endtask

    task automatic fill_mem(input logic random_data);
        for (int i = 0; i < LW; i++) mem[i] = random_data ? DW'($urandom) : DW'(32'h100 + i);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_q0.size() == 0 && exp_q1.size() == 0 && st0 == 2'd0 && st1 == 2'd0
                               && !s0.M_AXIS_TVALID && !s1.M_AXIS_TVALID)) begin
            cyc(1);
            n++;
        end
        compared++;
        if (n >= budget) begin
            mismatched++;
            $display("FAIL wait_idle: still busy after %0d cycles (left %0d/%0d beats)", n, exp_q0.size(), exp_q1.size());
        end
        cyc(3);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_line_cnt0"}, 64'(lc0), 64'(exp_line_cnt));
        chk({tag, "_line_cnt1"}, 64'(lc1), 64'(exp_line_cnt));
        chk({tag, "_overrun0"}, 64'(ovr0), 64'(exp_ovr));
        chk({tag, "_overrun1"}, 64'(ovr1), 64'(exp_ovr));
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int k, input logic v, input logic r, input logic u, input logic l,
                       input logic [DW-1:0] d);
        logic [EW-1:0] got, exp;
        logic          empty;
        got = {u, l, d};
        if (stall_prev[k]) begin
            compared++;
            if (!v || got !== stall_word[k]) begin
                mismatched++;
                $display("FAIL hold%0d: got v=%0b %0h expected v=1 %0h", k, v, got, stall_word[k]);
            end
        end
        if (gapless && run_prev[k] && r) begin
            compared++;
            if (!v) begin
                mismatched++;
                $display("FAIL gap%0d: got tvalid=0 expected tvalid=1 mid-line", k);
            end
        end
        if (v && r) begin
            compared++;
            empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                mismatched++;
                $display("FAIL beat%0d: got unexpected beat %0h expected none", k, got);
            end else begin
                if (k == 0) exp = exp_q0.pop_front();
                else        exp = exp_q1.pop_front();
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL beat%0d: got {user,last,data}=%0h expected %0h", k, got, exp);
                end
            end
            beats_seen[k]++;
        end
        stall_prev[k] = v && !r;
        stall_word[k] = got;
        run_prev[k]   = v && r && !l;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                stall_prev[k] = 1'b0;
                run_prev[k]   = 1'b0;
            end
        end else begin
            mon(0, s0.M_AXIS_TVALID, tready, s0.M_AXIS_TUSER, s0.M_AXIS_TLAST, s0.M_AXIS_TDATA);
            mon(1, s1.M_AXIS_TVALID, tready, s1.M_AXIS_TUSER, s1.M_AXIS_TLAST, s1.M_AXIS_TDATA);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 ns");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t_read, t0v, t1v, n;
        fill_mem(1'b0);

        // Reset values
        cyc(3);
        chk("rst_addrb0", 64'(addrb0), 64'd0);
        chk("rst_addrb1", 64'(addrb1), 64'd0);
        chk("rst_tvalid0", 64'(s0.M_AXIS_TVALID), 64'd0);
        chk("rst_tvalid1", 64'(s1.M_AXIS_TVALID), 64'd0);
        chk("rst_tuser0", 64'(s0.M_AXIS_TUSER), 64'd0);
        chk("rst_tlast0", 64'(s0.M_AXIS_TLAST), 64'd0);
        chk_status("rst");
        rst_n = 1'b1;
        rd_en = 1'b1;
        cyc(5);

        // 1: single line, TREADY held high, counting data 0x100..0x107, latency check
        gapless = 1'b1;
        vsync_rise();
        cyc(4);
        vsync = 1'b0;
        cyc(4);
        line_sel = ~line_sel;
        push_line();
        t_read = -1; t0v = -1; t1v = -1;
        for (int c = 0; c < 60 && (t0v < 0 || t1v < 0); c++) begin
            @(negedge clk);
            if (t_read < 0 && st0 == 2'd1) t_read = c;
            if (t_read >= 0 && t0v < 0 && s0.M_AXIS_TVALID) t0v = c;
            if (t_read >= 0 && t1v < 0 && s1.M_AXIS_TVALID) t1v = c;
        end
        chk("first_valid_lat1", 64'(t0v - t_read), 64'd2);
        chk("first_valid_lat2", 64'(t1v - t_read), 64'd3);
        wait_idle(200);
        chk_status("s1");
        gapless = 1'b0;

        // 2: same line shape, TREADY toggling every cycle
        fill_mem(1'b1);
        rdy_mode = 1;
        vsync_rise();
        cyc(4);
        vsync = 1'b0;
        cyc(4);
        line_sel = ~line_sel;
        push_line();
        wait_idle(300);
        chk_status("s2");

        // 3: VSYNC coincident with first of three spaced line events
        fill_mem(1'b1);
        rdy_mode = 0;
        gapless = 1'b1;
        cyc(2);
        vsync_rise();
        line_sel = ~line_sel;
        push_line();
        cyc(4);
        vsync = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc($urandom_range(16, 22));
            line_sel = ~line_sel;
            push_line();
        end
        wait_idle(300);
        chk_status("s3");
        gapless = 1'b0;

        // 4: backpressure holds line in READ; two more events -> one queued, one dropped
        fill_mem(1'b1);
        rdy_mode = 3;
        cyc(2);
        line_sel = ~line_sel;
        push_line();
        cyc(12);
        line_sel = ~line_sel;
        push_line();
        cyc(10);
        line_sel = ~line_sel;
        exp_ovr = 1'b1;
        cyc(10);
        chk("s4_overrun0_stalled", 64'(ovr0), 64'd1);
        chk("s4_overrun1_stalled", 64'(ovr1), 64'd1);
        rdy_mode = 2;
        wait_idle(600);
        chk_status("s4");

        // 5: events ignored while RD_EN is low
        rd_en = 1'b0;
        cyc(5);
        for (int i = 0; i < 30; i++) begin
            if (i % 8 == 0) line_sel = ~line_sel;
            cyc(1);
            chk("s5_addrb0", 64'(addrb0), 64'd0);
            chk("s5_addrb1", 64'(addrb1), 64'd0);
            chk("s5_tvalid0", 64'(s0.M_AXIS_TVALID), 64'd0);
        end
        rd_en = 1'b1;
        cyc(6);
        chk_status("s5");

        // 6: reset in the middle of a line, then a clean line
        fill_mem(1'b0);
        rdy_mode = 0;
        beats_seen[0] = 0;
        cyc(2);
        line_sel = ~line_sel;
        push_line();
        n = 0;
        while (beats_seen[0] < 4 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("s6_reached_beat4", 64'(beats_seen[0] >= 4), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_tvalid0_async", 64'(s0.M_AXIS_TVALID), 64'd0);
        chk("s6_tvalid1_async", 64'(s1.M_AXIS_TVALID), 64'd0);
        chk("s6_addrb0_async", 64'(addrb0), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_sof = 1'b0;
        exp_line_cnt = 0;
        exp_ovr = 1'b0;
        chk_status("s6_rst");
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        line_sel = ~line_sel;
        push_line();
        wait_idle(200);
        chk_status("s6");

        chk("end_queue0_empty", 64'(exp_q0.size()), 64'd0);
        chk("end_queue1_empty", 64'(exp_q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
